// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: datapath width, fetch FSM
// encoding, next-PC selector, and opcode constants also used by decode
// and immediate generation.
package instruction_fetch_pkg;

    localparam int XLEN = 64;

    // Canonical NOP (addi x0, x0, 0).
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // RV64I major opcodes, shared with decode and immediate generation.
    localparam logic [6:0] OPC_LOAD      = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC     = 7'b001_0111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b001_1011;
    localparam logic [6:0] OPC_STORE     = 7'b010_0011;
    localparam logic [6:0] OPC_OP        = 7'b011_0011;
    localparam logic [6:0] OPC_LUI       = 7'b011_0111;
    localparam logic [6:0] OPC_OP_32     = 7'b011_1011;
    localparam logic [6:0] OPC_BRANCH    = 7'b110_0011;
    localparam logic [6:0] OPC_JALR      = 7'b110_0111;
    localparam logic [6:0] OPC_JAL       = 7'b110_1111;

    // Fetch FSM encoding.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    // Source of the next PC value.
    typedef enum logic [1:0] {
        PC_KEEP,
        PC_INC,
        PC_REDIRECT,
        PC_PENDING
    } pc_sel_e;

    // Instructions are 4-byte aligned; only the two low bits matter.
    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack, decode valid/ready,
// downstream redirect, and the sticky error flag.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_error;

    // Fetch stage side.
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_error,
        input  imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    // Memory / decode / branch-resolution side.
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_error,
        output imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter with next-PC mux (hold / +4 / redirect / pending) and a
// pending-redirect register that parks a target while a stale fetch drains.
module instruction_fetch_pc_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_e         pc_sel_i,
    input  logic            pending_load_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_d_misaligned_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_pc_q, pending_pc_d;

    // Select the next PC and the next parked redirect target.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and infers a latch.
        pc_d         = pc_q;
        pending_pc_d = pending_load_i ? redirect_pc_i : pending_pc_q;
        unique case (pc_sel_i)
            PC_KEEP:     pc_d = pc_q;
            PC_INC:      pc_d = pc_q + XLEN'(4);
            PC_REDIRECT: pc_d = redirect_pc_i;
            PC_PENDING:  pc_d = pending_pc_q;
        endcase
    end

    assign pc_o              = pc_q;
    assign pc_d_misaligned_o = !is_aligned(pc_d[1:0]);

    // PC and pending-target registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments make each flop sample pre-edge values independent of statement order.
        if (rst) begin
            pc_q         <= RESET_PC;
            pending_pc_q <= RESET_PC;
        end else begin
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding instruction-memory request at a time, holds
// the fetched word for decode, and honours redirects by dropping or draining
// stale fetches. A misaligned PC load parks the stage in ERROR until reset.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input logic                 clk,
    input logic                 rst,
    instruction_fetch_if.master fetch_if
);

    logic [2:0]      state_q, state_d, state_base_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [XLEN-1:0] pc;
    logic            pc_d_misaligned;
    logic            pending_load;
    pc_sel_e         pc_sel;

    instruction_fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk               (clk),
        .rst               (rst),
        .pc_sel_i          (pc_sel),
        .pending_load_i    (pending_load),
        .redirect_pc_i     (fetch_if.redirect_pc),
        .pc_o              (pc),
        .pc_d_misaligned_o (pc_d_misaligned)
    );

    // Sequencing: choose PC source, capture fetched word, pick next state.
    always_comb begin
        state_base_d = state_q;
        pc_sel       = PC_KEEP;
        pending_load = 1'b0;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_if.redirect_valid) pc_sel = PC_REDIRECT;
                state_base_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (fetch_if.imem_ack) begin
                    if (fetch_if.redirect_valid) begin
                        // Returned word is stale; start over at the target.
                        pc_sel = PC_REDIRECT;
                    end else begin
                        inst_d       = fetch_if.imem_rdata;
                        inst_pc_d    = pc;
                        state_base_d = ST_HOLD;
                    end
                end else if (fetch_if.redirect_valid) begin
                    // The request cannot be withdrawn; park the target.
                    pending_load = 1'b1;
                    state_base_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pending_load = fetch_if.redirect_valid;
                if (fetch_if.imem_ack) begin
                    pc_sel       = fetch_if.redirect_valid ? PC_REDIRECT : PC_PENDING;
                    state_base_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (fetch_if.redirect_valid) begin
                    pc_sel       = PC_REDIRECT;
                    state_base_d = ST_FETCH;
                end else if (fetch_if.inst_ready) begin
                    pc_sel       = PC_INC;
                    state_base_d = ST_FETCH;
                end
            end
            ST_ERROR: state_base_d = ST_ERROR;
            default:  state_base_d = ST_IDLE;
        endcase
    end

    // Any PC load that lands misaligned diverts to ERROR instead of FETCH.
    assign state_d = (pc_sel != PC_KEEP && pc_d_misaligned) ? ST_ERROR : state_base_d;

    // State and held-instruction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            inst_q    <= '0;
            inst_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign fetch_if.imem_req    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign fetch_if.imem_addr   = pc;
    assign fetch_if.inst_valid  = (state_q == ST_HOLD);
    assign fetch_if.inst        = inst_q;
    assign fetch_if.inst_pc     = inst_pc_q;
    assign fetch_if.fetch_error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized traffic, compared every cycle against a transaction-level model
// of the fetch stage (outstanding request, stale flag, held instruction).
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam logic [63:0] RST_PC = 64'h100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_if (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the fetch stage should be doing this cycle.
    bit          m_err, m_idle, m_busy, m_stale, m_held;
    logic [63:0] m_addr, m_target, m_inst_pc;
    logic [31:0] m_inst;
    logic [63:0] delivered_q[$];

    // Memory behaviour.
    int lat      = 0;
    int wait_cnt = 0;
    bit const_mem = 1'b1;
    bit force_ack = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (const_mem) return 32'h00A0_0093;
        return a[33:2] ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_err = 0; m_idle = 1; m_busy = 0; m_stale = 0; m_held = 0;
        m_addr = RST_PC; m_target = RST_PC; m_inst = '0; m_inst_pc = RST_PC;
        wait_cnt = 0;
    endtask

    task automatic start_fetch(input logic [63:0] a);
        m_held   = 0;
        m_stale  = 0;
        wait_cnt = 0;
        if (a[1:0] != 2'b00) begin
            m_err  = 1;
            m_busy = 0;
        end else begin
            m_busy = 1;
            m_addr = a;
        end
    endtask

    // One cycle: called just after a falling edge; compares outputs, drives
    // inputs, advances the model, and returns at the next falling edge.
    task automatic step(input logic ready, input logic redir, input logic [63:0] rpc);
        logic        ack;
        logic [31:0] rd;
        check("imem_req", bus.imem_req, m_busy);
        if (m_busy) check("imem_addr", bus.imem_addr, m_addr);
        check("inst_valid", bus.inst_valid, m_held);
        if (m_held) begin
            check("inst", bus.inst, m_inst);
            check("inst_pc", bus.inst_pc, m_inst_pc);
        end
        check("fetch_error", bus.fetch_error, m_err);

        ack = force_ack || (m_busy && wait_cnt >= lat);
        rd  = mem_word(m_addr);
        bus.imem_ack       = ack;
        bus.imem_rdata     = rd;
        bus.inst_ready     = ready;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;

        if (m_err) begin
            // Only reset leaves the error condition.
        end else if (m_idle) begin
            m_idle = 0;
            start_fetch(redir ? rpc : RST_PC);
        end else if (m_busy) begin
            if (!m_stale) begin
                if (ack && !redir) begin
                    m_held    = 1;
                    m_inst    = rd;
                    m_inst_pc = m_addr;
                    m_busy    = 0;
                    delivered_q.push_back(m_addr);
                end else if (ack) begin
                    start_fetch(rpc);
                end else if (redir) begin
                    m_stale  = 1;
                    m_target = rpc;
                end
            end else begin
                if (redir) m_target = rpc;
                if (ack) start_fetch(m_target);
            end
            if (m_busy && !ack) wait_cnt++;
        end else if (m_held) begin
            if (redir) start_fetch(rpc);
            else if (ready) start_fetch(m_inst_pc + 64'd4);
        end
        @(negedge clk);
    endtask

    // Asserts reset asynchronously mid-cycle, checks reset values, releases
    // it on a falling edge so the next step() sees the IDLE cycle.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        bus.imem_ack = 0; bus.imem_rdata = '0; bus.inst_ready = 0;
        bus.redirect_valid = 0; bus.redirect_pc = '0;
        model_reset();
        #1;
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_imem_addr", bus.imem_addr, RST_PC);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_inst", bus.inst, 0);
        check("rst_inst_pc", bus.inst_pc, RST_PC);
        check("rst_fetch_error", bus.fetch_error, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          guard;
        logic        redir;
        logic [63:0] rpc;

        bus.imem_ack = 0; bus.imem_rdata = '0; bus.inst_ready = 0;
        bus.redirect_valid = 0; bus.redirect_pc = '0;
        model_reset();
        @(negedge clk);

        // Zero-wait memory, decode always ready.
        do_reset();
        lat = 0; const_mem = 1;
        repeat (8) step(1, 0, '0);
        check("t1_delivered_count", delivered_q.size() >= 3, 1);
        if (delivered_q.size() >= 3) begin
            check("t1_pc0", delivered_q[0], 64'h100);
            check("t1_pc1", delivered_q[1], 64'h104);
            check("t1_pc2", delivered_q[2], 64'h108);
        end

        // Three-cycle memory, decode stalls five cycles with an instruction held.
        const_mem = 0; lat = 3;
        step(1, 0, '0);
        guard = 0;
        while (!m_held && guard < 20) begin step(0, 0, '0); guard++; end
        check("t2_wait_held", guard < 20, 1);
        repeat (5) step(0, 0, '0);
        check("t2_held_pc", bus.inst_pc, 64'h110);
        step(1, 0, '0);
        check("t2_next_addr", bus.imem_addr, 64'h114);

        // Redirect while FETCH waits on 0x104: drain, then fetch 0x200.
        do_reset();
        guard = 0;
        while (!(m_busy && !m_stale && m_addr == 64'h104) && guard < 30) begin step(1, 0, '0); guard++; end
        check("t3_reach_104", guard < 30, 1);
        step(1, 1, 64'h200);
        check("t3_drain_req", bus.imem_req, 1);
        check("t3_drain_addr", bus.imem_addr, 64'h104);
        guard = 0;
        while (!m_held && guard < 30) begin step(1, 0, '0); guard++; end
        check("t3_wait_held", guard < 30, 1);
        check("t3_first_pc", bus.inst_pc, 64'h200);

        // Redirect in HOLD together with inst_ready: redirect wins over +4.
        step(1, 1, 64'h300);
        check("t4_req", bus.imem_req, 1);
        check("t4_addr", bus.imem_addr, 64'h300);

        // PC wrap-around at the top of the address space.
        guard = 0;
        while (!m_held && guard < 20) begin step(0, 0, '0); guard++; end
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        guard = 0;
        while (!m_held && guard < 20) begin step(0, 0, '0); guard++; end
        check("t5_wait_held", guard < 20, 1);
        check("t5_top_pc", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1, 0, '0);
        check("t5_wrap_req", bus.imem_req, 1);
        check("t5_wrap_addr", bus.imem_addr, 64'h0);

        // Misaligned redirect from HOLD: sticky error, redirects ignored.
        guard = 0;
        while (!m_held && guard < 20) begin step(0, 0, '0); guard++; end
        step(0, 1, 64'h202);
        check("t6_error", bus.fetch_error, 1);
        check("t6_no_req", bus.imem_req, 0);
        repeat (10) step(1, 1, 64'h400);
        check("t6_error_sticky", bus.fetch_error, 1);
        check("t6_no_req_sticky", bus.imem_req, 0);

        // Reset recovers; a late ack during IDLE is ignored.
        do_reset();
        force_ack = 1;
        step(0, 0, '0);
        force_ack = 0;
        check("t7_req", bus.imem_req, 1);
        check("t7_addr", bus.imem_addr, RST_PC);

        // Misaligned redirect seen in DRAIN takes effect after the ack.
        step(1, 1, 64'h2002);
        check("t8_no_error_yet", bus.fetch_error, 0);
        check("t8_drain_addr", bus.imem_addr, RST_PC);
        repeat (4) step(1, 0, '0);
        check("t8_error", bus.fetch_error, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (m_err && $urandom_range(0, 3) == 0) do_reset();
            if (!m_busy) lat = $urandom_range(0, 3);
            redir = ($urandom_range(0, 7) == 0);
            rpc   = {$urandom(), $urandom()} & ~64'h3;
            if ($urandom_range(0, 15) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step(1'($urandom_range(0, 1)), redir, rpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the sequential RISC-V core: owns the program counter, issues one request at a time to instruction memory over a req/ack handshake, and presents the fetched 32-bit word with its PC to decode/immediate generation over a valid/ready handshake. Accepts a PC redirect (taken branch target computed downstream) at any time and discards stale fetches. Sits directly upstream of decode and the immediate generator.

## Interface
- RESET_PC, 64'h0, PC loaded on reset; must be 4-byte aligned
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  64  fetch address; stable while imem_req high and no ack
- imem_ack  in  1  memory response valid; may assert in the same cycle as imem_req
- imem_rdata  in  32  instruction word, valid when imem_ack high
- inst_valid  out  1  held instruction available to decode
- inst  out  32  instruction word
- inst_pc  out  64  PC of inst
- inst_ready  in  1  decode accepts inst this cycle
- redirect_valid  in  1  load redirect_pc as next fetch PC
- redirect_pc  in  64  redirect target
- fetch_error  out  1  sticky: PC became misaligned

## Operation
- States: IDLE, FETCH, HOLD, DRAIN, ERROR. Registers: pc, pending_pc, inst, inst_pc.
- imem_req = 1 in FETCH and DRAIN only; imem_addr = pc.
- IDLE: -> FETCH next cycle unconditionally.
- FETCH, ack=1, no redirect: inst<=imem_rdata, inst_pc<=pc, -> HOLD.
- FETCH, ack=1, redirect: data discarded, pc<=redirect_pc, stay FETCH (new transaction).
- FETCH, ack=0, redirect: pending_pc<=redirect_pc, -> DRAIN (request cannot be withdrawn).
- DRAIN: req held at old pc; further redirects overwrite pending_pc (last wins). On ack: data discarded, pc<=pending_pc (or redirect_pc if redirect in same cycle), -> FETCH.
- HOLD: inst_valid=1. inst_ready & no redirect: pc<=pc+4 (wraps modulo 2^64), -> FETCH. Redirect (with or without inst_ready): pc<=redirect_pc, -> FETCH; redirect has priority, held instruction dropped unless consumed in that same cycle.
- Any load of pc with pc[1:0]!=0: -> ERROR instead of FETCH. ERROR: no requests, inst_valid=0, fetch_error=1, exits only by reset. Misaligned redirect seen in DRAIN takes effect only after the outstanding ack.
- Redirect in IDLE/ERROR: IDLE loads pc; ERROR ignores.

## Timing
- Reset values: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=RESET_PC, fetch_error=0.
- First imem_req in cycle 1 after rst deasserts.
- Ack in request cycle n -> inst_valid in n+1. Consume in cycle m -> next imem_req in m+1. Peak throughput: 1 instruction / 2 cycles.
- Redirect in HOLD at cycle n -> request to redirect_pc in n+1.
- rst mid-transaction aborts all state immediately; a late ack after reset is ignored (state IDLE).
- inst/inst_pc stable while inst_valid=1 and not consumed.

## Structure
- Shared package/header: state encoding, INST_NOP (32'h00000013), opcode constants shared with decode/immediate generation, XLEN=64.
- Natural sub-module: pc_reg (PC register with next-PC mux: pc+4 / redirect / pending, alignment check output).

## Test plan
- Reset RESET_PC=64'h100, zero-wait memory returning 32'h00A00093: imem_addr sequence 100,104,108 with inst_ready=1; inst_valid every other cycle, inst_pc matches.
- Memory 3-cycle latency, inst_ready held low 5 cycles: imem_addr stable until ack, inst held stable, no new req until consumed.
- Redirect to 64'h200 while FETCH waiting on ack at 64'h104: state DRAIN, req stays at 104, ack data never reaches inst_valid, next request at 200.
- Redirect to 64'h300 in HOLD same cycle as inst_ready: next request 300, not pc+4.
- Redirect to 64'h202 (misaligned): fetch_error=1, imem_req=0 permanently until rst; rst restores RESET_PC fetch.
- pc=64'hFFFF_FFFF_FFFF_FFFC consumed: next request at 64'h0.
